mem_responder: RTL and testbench

- Memory-side responder for the CPU control FSM's fetch and data-memory handshake.
- Accepts a request (req/we/addr/wdata/byte_sel) from the core and drives an asynchronous 16-bit SRAM with a fixed number of wait states.
- Holds mem_wait high until the access completes, then returns read data.
- Sits between the core's memory port and the board-level SRAM pins; the tristate buffer is in the top level.

---
 rtl/mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder between the core's memory port and an
// asynchronous 16-bit SRAM. A request taken in IDLE is latched, the SRAM is
// strobed for WAIT_STATES+1 cycles in ACCESS, and DONE lasts one cycle. DONE
// releases the core and holds the write data on the bus.
module mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic              byte_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic              mem_wait,
    output logic [15:0]       rdata,
    output logic [ADDR_W-2:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              we_q, we_q_n;
    logic              byte_q, byte_q_n;
    logic              lane_hi_q, lane_hi_q_n;
    logic [15:0]       rdata_n;
    logic [ADDR_W-2:0] sram_addr_n;
    logic [15:0]       sram_dq_o_n;
    logic              sram_dq_oe_n;
    logic              sram_ce_n_n;
    logic              sram_oe_n_n;
    logic              sram_we_n_n;
    logic              sram_ub_n_n;
    logic              sram_lb_n_n;

    // The stall is gated by req so that the core never sees a false
    // completion, and so that a dropped request reads as not waiting.
    assign mem_wait = req && (state != DONE);

    // State register and registered SRAM pins. Reset also aborts any access
    // in flight and releases every strobe at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            lane_hi_q  <= 1'b0;
            rdata      <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            we_q       <= we_q_n;
            byte_q     <= byte_q_n;
            lane_hi_q  <= lane_hi_q_n;
            rdata      <= rdata_n;
            sram_addr  <= sram_addr_n;
            sram_dq_o  <= sram_dq_o_n;
            sram_dq_oe <= sram_dq_oe_n;
            sram_ce_n  <= sram_ce_n_n;
            sram_oe_n  <= sram_oe_n_n;
            sram_we_n  <= sram_we_n_n;
            sram_ub_n  <= sram_ub_n_n;
            sram_lb_n  <= sram_lb_n_n;
        end
    end

    // Next-state and next-pin logic. Every register holds its value unless a
    // state explicitly changes it. This keeps the address and write data
    // stable through DONE for write hold time.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        we_q_n       = we_q;
        byte_q_n     = byte_q;
        lane_hi_q_n  = lane_hi_q;
        rdata_n      = rdata;
        sram_addr_n  = sram_addr;
        sram_dq_o_n  = sram_dq_o;
        sram_dq_oe_n = sram_dq_oe;
        sram_ce_n_n  = sram_ce_n;
        sram_oe_n_n  = sram_oe_n;
        sram_we_n_n  = sram_we_n;
        sram_ub_n_n  = sram_ub_n;
        sram_lb_n_n  = sram_lb_n;

        case (state)
            IDLE: begin
                if (req) begin
                    we_q_n       = we;
                    byte_q_n     = byte_sel;
                    lane_hi_q_n  = addr[0];
                    sram_addr_n  = addr[ADDR_W-1:1];
                    sram_dq_o_n  = byte_sel ? {wdata[7:0], wdata[7:0]} : wdata;
                    sram_dq_oe_n = we;
                    sram_ce_n_n  = 1'b0;
                    sram_oe_n_n  = we;
                    sram_we_n_n  = !we;
                    sram_ub_n_n  = byte_sel && !addr[0];
                    sram_lb_n_n  = byte_sel && addr[0];
                    cnt_n        = WAIT_INIT;
                    state_n      = ACCESS;
                end else begin
                    sram_dq_oe_n = 1'b0;
                    sram_ce_n_n  = 1'b1;
                    sram_oe_n_n  = 1'b1;
                    sram_we_n_n  = 1'b1;
                    sram_ub_n_n  = 1'b1;
                    sram_lb_n_n  = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    if (!we_q) begin
                        if (byte_q) begin
                            rdata_n = {8'h00, lane_hi_q ? sram_dq_i[15:8] : sram_dq_i[7:0]};
                        end else begin
                            rdata_n = sram_dq_i;
                        end
                    end
                    sram_ce_n_n = 1'b1;
                    sram_oe_n_n = 1'b1;
                    sram_we_n_n = 1'b1;
                    state_n     = DONE;
                end
            end
            DONE: begin
                sram_dq_oe_n = 1'b0;
                sram_ub_n_n  = 1'b1;
                sram_lb_n_n  = 1'b1;
                state_n      = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with a scoreboard of
// expected read data and latency. A second pair of instances, built with
// WAIT_STATES of 0 and 3, covers the latency extremes.
module tb_mem_responder;

    localparam int WS_MAIN = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req, we, byte_sel;
    logic [15:0] addr, wdata, sram_dq_i;
    logic        mem_wait, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [15:0] rdata, sram_dq_o;
    logic [14:0] sram_addr;

    // Shared stimulus for the WAIT_STATES=0 and WAIT_STATES=3 instances
    logic        req2;
    logic [15:0] addr2, wdata2, dqi2;
    logic        mw0, oe0, ce0, oen0, wen0, ub0, lb0;
    logic        mw3, oe3, ce3, oen3, wen3, ub3, lb3;
    logic [15:0] rd0, dqo0, rd3, dqo3;
    logic [14:0] sa0, sa3;

    mem_responder #(.ADDR_W(16), .WAIT_STATES(WS_MAIN)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .byte_sel(byte_sel), .addr(addr),
        .wdata(wdata), .mem_wait(mem_wait), .rdata(rdata), .sram_addr(sram_addr),
        .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    mem_responder #(.ADDR_W(16), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst), .req(req2), .we(1'b1), .byte_sel(1'b0), .addr(addr2),
        .wdata(wdata2), .mem_wait(mw0), .rdata(rd0), .sram_addr(sa0),
        .sram_dq_o(dqo0), .sram_dq_i(dqi2), .sram_dq_oe(oe0),
        .sram_ce_n(ce0), .sram_oe_n(oen0), .sram_we_n(wen0),
        .sram_ub_n(ub0), .sram_lb_n(lb0)
    );

    mem_responder #(.ADDR_W(16), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .rst(rst), .req(req2), .we(1'b1), .byte_sel(1'b0), .addr(addr2),
        .wdata(wdata2), .mem_wait(mw3), .rdata(rd3), .sram_addr(sa3),
        .sram_dq_o(dqo3), .sram_dq_i(dqi2), .sram_dq_oe(oe3),
        .sram_ce_n(ce3), .sram_oe_n(oen3), .sram_we_n(wen3),
        .sram_ub_n(ub3), .sram_lb_n(lb3)
    );

    typedef struct {
        logic [15:0] rdata;
        int          latency;
    } exp_t;

    exp_t        sbQueue[$];
    logic [15:0] modelRdata;
    int          testsRun = 0;
    int          testsFailed = 0;

    // One comparison: counts it and reports observed vs expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts an access on the main instance in cycle 0 and queues the expected result
    task automatic applyStimulus(input string tag, input logic isWrite, input logic isByte,
                                 input logic [15:0] a, input logic [15:0] wd, input logic [15:0] dqi);
        exp_t e;
        if (isWrite) e.rdata = modelRdata;
        else if (isByte) e.rdata = {8'h00, a[0] ? dqi[15:8] : dqi[7:0]};
        else e.rdata = dqi;
        e.latency = WS_MAIN + 2;
        modelRdata = e.rdata;
        sbQueue.push_back(e);
        @(negedge clk);
        req = 1'b1; we = isWrite; byte_sel = isByte; addr = a; wdata = wd; sram_dq_i = dqi;
        #1;
        checkOutput({tag, "_wait_c0"}, 32'(mem_wait), 32'd1);
    endtask

    // Follows the access to DONE, popping the scoreboard and checking pins on the way
    task automatic completeAccess(input string tag, input logic isWrite, input logic isByte,
                                  input logic [15:0] a, input logic [15:0] wd, input logic keepReq);
        exp_t        e;
        int          cyc;
        int          oeLow;
        int          weLow;
        logic        sawDone;
        logic [1:0]  lanes;
        logic [14:0] addrSeen;
        e = sbQueue.pop_front();
        cyc = 0; oeLow = 0; weLow = 0; sawDone = 1'b0; lanes = 2'b11; addrSeen = '0;
        while (cyc < 20 && !sawDone) begin
            @(negedge clk); #1;
            cyc++;
            if (mem_wait === 1'b0) begin
                sawDone = 1'b1;
            end else begin
                if (sram_oe_n === 1'b0) oeLow++;
                if (sram_we_n === 1'b0) weLow++;
                if (cyc == 1) begin
                    lanes = {sram_ub_n, sram_lb_n};
                    addrSeen = sram_addr;
                end
            end
        end
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(e.latency));
        checkOutput({tag, "_sram_addr"}, 32'(addrSeen), 32'(a[15:1]));
        checkOutput({tag, "_lanes"}, 32'(lanes), isByte ? (a[0] ? 32'd1 : 32'd2) : 32'd0);
        checkOutput({tag, "_oe_low"}, 32'(oeLow), isWrite ? 32'd0 : 32'(WS_MAIN + 1));
        checkOutput({tag, "_we_low"}, 32'(weLow), isWrite ? 32'(WS_MAIN + 1) : 32'd0);
        checkOutput({tag, "_done_strobes"}, 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b111);
        checkOutput({tag, "_done_dq_oe"}, 32'(sram_dq_oe), 32'(isWrite));
        checkOutput({tag, "_rdata"}, 32'(rdata), 32'(e.rdata));
        if (isWrite)
            checkOutput({tag, "_dq_o"}, 32'(sram_dq_o), isByte ? 32'({wd[7:0], wd[7:0]}) : 32'(wd));
        if (!keepReq) begin
            req = 1'b0;
            @(negedge clk); #1;
            checkOutput({tag, "_idle_pins"},
                        32'({sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}),
                        32'b011111);
        end
    endtask

    initial begin
        int   lat0;
        int   lat3;
        exp_t dropped;
        rst = 1'b1; req = 1'b0; we = 1'b0; byte_sel = 1'b0; addr = '0; wdata = '0; sram_dq_i = '0;
        req2 = 1'b0; addr2 = 16'h0088; wdata2 = 16'h6B6B; dqi2 = 16'h0F0F;
        modelRdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        checkOutput("reset_mem_wait", 32'(mem_wait), 32'd0);
        checkOutput("reset_rdata", 32'(rdata), 32'd0);
        checkOutput("reset_addr_dq", 32'({1'b0, sram_addr, sram_dq_o}), 32'd0);
        checkOutput("reset_pins",
                    32'({sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}),
                    32'b011111);

        // Word read, word write, byte read, byte write
        applyStimulus("word_rd", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        completeAccess("word_rd", 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
        applyStimulus("word_wr", 1'b1, 1'b0, 16'h0021, 16'h1234, 16'h9999);
        completeAccess("word_wr", 1'b1, 1'b0, 16'h0021, 16'h1234, 1'b0);
        applyStimulus("byte_rd", 1'b0, 1'b1, 16'h0003, 16'h0000, 16'hA55A);
        completeAccess("byte_rd", 1'b0, 1'b1, 16'h0003, 16'h0000, 1'b0);
        applyStimulus("byte_wr", 1'b1, 1'b1, 16'h0002, 16'h00C3, 16'h7777);
        completeAccess("byte_wr", 1'b1, 1'b1, 16'h0002, 16'h00C3, 1'b0);
        applyStimulus("byte_rd_lo", 1'b0, 1'b1, 16'h0004, 16'h0000, 16'hA55A);
        completeAccess("byte_rd_lo", 1'b0, 1'b1, 16'h0004, 16'h0000, 1'b0);

        // Back-to-back: req held through DONE, second access starts in the next IDLE
        applyStimulus("b2b_1", 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1111);
        completeAccess("b2b_1", 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1);
        applyStimulus("b2b_2", 1'b0, 1'b0, 16'h0042, 16'h0000, 16'h2222);
        completeAccess("b2b_2", 1'b0, 1'b0, 16'h0042, 16'h0000, 1'b0);

        // req dropped in ACCESS: access completes, inputs changed mid-access are ignored
        applyStimulus("drop", 1'b0, 1'b0, 16'h0060, 16'h0000, 16'h3C3C);
        dropped = sbQueue.pop_front();
        @(negedge clk);
        req = 1'b0; addr = 16'h0ABC; we = 1'b1;
        #1;
        checkOutput("drop_wait_c1", 32'(mem_wait), 32'd0);
        @(negedge clk); #1;
        checkOutput("drop_addr_held", 32'(sram_addr), 32'h0030);
        checkOutput("drop_oe_c2", 32'(sram_oe_n), 32'd0);
        @(negedge clk); #1;
        checkOutput("drop_rdata", 32'(rdata), 32'(dropped.rdata));
        @(negedge clk); #1;
        checkOutput("drop_idle_pins",
                    32'({sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}),
                    32'b011111);

        // Reset asserted during ACCESS of a write
        applyStimulus("rst_wr", 1'b1, 1'b0, 16'h0100, 16'hFFFF, 16'h0000);
        void'(sbQueue.pop_front());
        @(negedge clk); #1;
        checkOutput("rst_wr_we_active", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        @(negedge clk); #1;
        modelRdata = '0;
        checkOutput("rst_wr_strobes", 32'({sram_ce_n, sram_we_n, sram_dq_oe}), 32'b110);
        checkOutput("rst_wr_rdata", 32'(rdata), 32'(modelRdata));
        checkOutput("rst_wr_mem_wait", 32'(mem_wait), 32'(req));
        rst = 1'b0; req = 1'b0;
        #1;
        checkOutput("rst_wr_mem_wait_low", 32'(mem_wait), 32'd0);

        // Recovery after reset
        applyStimulus("post_rst_rd", 1'b0, 1'b0, 16'h0200, 16'h0000, 16'h5A5A);
        completeAccess("post_rst_rd", 1'b0, 1'b0, 16'h0200, 16'h0000, 1'b0);

        // Latency extremes: WAIT_STATES=0 and WAIT_STATES=3 builds (writes)
        lat0 = -1; lat3 = -1;
        @(negedge clk);
        req2 = 1'b1;
        #1;
        checkOutput("ws_wait_c0", 32'({mw0, mw3}), 32'b11);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); #1;
            if (lat0 < 0 && mw0 === 1'b0) begin
                lat0 = c;
                checkOutput("ws0_dq_o", 32'(dqo0), 32'h6B6B);
                checkOutput("ws0_dq_oe_done", 32'(oe0), 32'd1);
            end
            if (lat3 < 0 && mw3 === 1'b0) begin
                lat3 = c;
                checkOutput("ws3_dq_o", 32'(dqo3), 32'h6B6B);
                checkOutput("ws3_dq_oe_done", 32'(oe3), 32'd1);
            end
        end
        checkOutput("ws0_latency", 32'(lat0), 32'd2);
        checkOutput("ws3_latency", 32'(lat3), 32'd5);
        req2 = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("ws_rdata_untouched", 32'({rd0, rd3}), 32'd0);
        checkOutput("ws_sram_addr", 32'({1'b0, sa0, 1'b0, sa3}), 32'({1'b0, 15'h0044, 1'b0, 15'h0044}));
        checkOutput("ws_idle_pins",
                    32'({oe0, ce0, oen0, wen0, ub0, lb0, oe3, ce3, oen3, wen3, ub3, lb3}),
                    32'b011111_011111);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
